// File: rtl/tgt_pyld_st_arb_if.sv
// tgt_pyld_st_arb_if
//   Merged payload-store stream between the arbiter and the payload buffer
//   store port.
//   valid/last/blen/qnum/data : beat from the selected producer
//   ready                     : store port accepts the beat
//   modport master : arbiter side (drives the beat, samples ready)
//   modport slave  : payload buffer side
`ifndef MSG_BLEN_WIDTH
`define MSG_BLEN_WIDTH 16
`endif
`ifndef P2P_DATA_W
`define P2P_DATA_W 64
`endif

interface tgt_pyld_st_arb_if;
    logic                       valid;
    logic                       last;
    logic [`MSG_BLEN_WIDTH-1:0] blen;
    logic [7:0]                 qnum;
    logic [`P2P_DATA_W-1:0]     data;
    logic                       ready;

    modport master (output valid, last, blen, qnum, data, input ready);
    modport slave  (input valid, last, blen, qnum, data, output ready);
endinterface

// File: rtl/tgt_pyld_st_arb.sv
// tgt_pyld_st_arb
//   Round-robin, message-atomic arbiter sharing the payload-buffer store port
//   among REQ_NUM producers. Once a message starts (or is presented without
//   being accepted) the grant stays with that producer until its last beat
//   is accepted, so messages never interleave.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_last  : per-requester beat valid / last beat
//   in_blen/qnum/data : per-requester fields, requester i in slice i
//   in_ready          : per-requester ready, one-hot or zero
//   st_pyld_req       : merged store stream (interface, master side)
//   arb_owner         : currently selected requester
//   arb_busy          : message lock held
//   msg_cnt           : per-requester completed-message counters, present
//                       only when TGT_PYLD_ARB_STAT_EN is defined
`ifndef MSG_BLEN_WIDTH
`define MSG_BLEN_WIDTH 16
`endif
`ifndef P2P_DATA_W
`define P2P_DATA_W 64
`endif

// Per-requester 16-bit wrapping message counter.
module tgt_pyld_st_arb_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (inc) cnt <= cnt + 16'd1;
    end
endmodule

module tgt_pyld_st_arb #(
    parameter int REQ_NUM   = 4,
    parameter int REQ_IDX_W = $clog2(REQ_NUM)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [REQ_NUM-1:0]                      in_valid,
    input  logic [REQ_NUM-1:0]                      in_last,
    input  logic [REQ_NUM-1:0][`MSG_BLEN_WIDTH-1:0] in_blen,
    input  logic [REQ_NUM-1:0][7:0]                 in_qnum,
    input  logic [REQ_NUM-1:0][`P2P_DATA_W-1:0]     in_data,
    output logic [REQ_NUM-1:0]                      in_ready,
    tgt_pyld_st_arb_if.master                       st_pyld_req,
    output logic [REQ_IDX_W-1:0]                    arb_owner,
    output logic                                    arb_busy
`ifdef TGT_PYLD_ARB_STAT_EN
    ,
    output logic [REQ_NUM-1:0][15:0]                msg_cnt
`endif
);
    localparam logic [0:0]           IDLE     = 1'b0;
    localparam logic [0:0]           LOCKED   = 1'b1;
    localparam logic [REQ_IDX_W-1:0] LAST_IDX = REQ_IDX_W'(REQ_NUM - 1);

    logic [0:0]           lock;
    logic [REQ_IDX_W-1:0] owner, rr_ptr, rr_sel, sel;
    logic                 st_valid, st_last, hs;

    // base + k modulo REQ_NUM with an explicit compare (REQ_NUM need not be 2^n)
    function automatic logic [REQ_IDX_W-1:0] wrap_add(input logic [REQ_IDX_W-1:0] base,
                                                      input int k);
        int s;
        s = 32'(base) + k;
        if (s >= REQ_NUM) s = s - REQ_NUM;
        return REQ_IDX_W'(s);
    endfunction

    // Scan from the far end back to rr_ptr so the nearest valid wins.
    always_comb begin
        rr_sel = rr_ptr;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (in_valid[wrap_add(rr_ptr, k)]) rr_sel = wrap_add(rr_ptr, k);
        end
    end

    assign sel      = (lock == LOCKED) ? owner : rr_sel;
    assign st_valid = (lock == LOCKED) ? in_valid[owner] : |in_valid;
    assign st_last  = st_valid & in_last[sel];
    assign hs       = st_valid & st_pyld_req.ready;

    // Fields are zeroed while nothing is offered so the port is quiet when idle.
    assign st_pyld_req.valid = st_valid;
    assign st_pyld_req.last  = st_last;
    assign st_pyld_req.blen  = st_valid ? in_blen[sel] : '0;
    assign st_pyld_req.qnum  = st_valid ? in_qnum[sel] : '0;
    assign st_pyld_req.data  = st_valid ? in_data[sel] : '0;

    assign arb_owner = sel;
    assign arb_busy  = lock;

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_rdy
        assign in_ready[i] = (sel == REQ_IDX_W'(i)) & st_pyld_req.ready & st_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock   <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (hs && st_last) begin
            lock   <= IDLE;
            rr_ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
        end else if (hs) begin
            lock   <= LOCKED;
            owner  <= sel;
        end else if (lock == IDLE && st_valid) begin
            // Presented but not accepted: freeze the choice so a later,
            // higher-priority arrival cannot swap the beat under the consumer.
            lock   <= LOCKED;
            owner  <= sel;
        end
    end

`ifdef TGT_PYLD_ARB_STAT_EN
    for (genvar i = 0; i < REQ_NUM; i++) begin : g_cnt
        tgt_pyld_st_arb_cnt u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (hs & st_last & (sel == REQ_IDX_W'(i))),
            .cnt (msg_cnt[i])
        );
    end
`endif
endmodule

// File: tb/tb_tgt_pyld_st_arb.sv
`ifndef MSG_BLEN_WIDTH
`define MSG_BLEN_WIDTH 16
`endif
`ifndef P2P_DATA_W
`define P2P_DATA_W 64
`endif

module tb_tgt_pyld_st_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-requester instance
    logic                             rst4;
    logic [3:0]                       v4, l4;
    logic [3:0][`MSG_BLEN_WIDTH-1:0]  blen4;
    logic [3:0][7:0]                  qnum4;
    logic [3:0][`P2P_DATA_W-1:0]      data4;
    logic [3:0]                       rdy4;
    logic [1:0]                       own4;
    logic                             busy4;
    tgt_pyld_st_arb_if st4();
`ifdef TGT_PYLD_ARB_STAT_EN
    logic [3:0][15:0]                 cnt4;
`endif

    tgt_pyld_st_arb #(.REQ_NUM(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(v4), .in_last(l4), .in_blen(blen4),
        .in_qnum(qnum4), .in_data(data4), .in_ready(rdy4), .st_pyld_req(st4),
        .arb_owner(own4), .arb_busy(busy4)
`ifdef TGT_PYLD_ARB_STAT_EN
        , .msg_cnt(cnt4)
`endif
    );

    // 3-requester instance (non power-of-two wrap)
    logic                             rst3;
    logic [2:0]                       v3, l3;
    logic [2:0][`MSG_BLEN_WIDTH-1:0]  blen3;
    logic [2:0][7:0]                  qnum3;
    logic [2:0][`P2P_DATA_W-1:0]      data3;
    logic [2:0]                       rdy3;
    logic [1:0]                       own3;
    logic                             busy3;
    tgt_pyld_st_arb_if st3();
`ifdef TGT_PYLD_ARB_STAT_EN
    logic [2:0][15:0]                 cnt3;
`endif

    tgt_pyld_st_arb #(.REQ_NUM(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(v3), .in_last(l3), .in_blen(blen3),
        .in_qnum(qnum3), .in_data(data3), .in_ready(rdy3), .st_pyld_req(st3),
        .arb_owner(own3), .arb_busy(busy3)
`ifdef TGT_PYLD_ARB_STAT_EN
        , .msg_cnt(cnt3)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       rdy;
        logic [7:0] tag;
        logic       e_vld;
        logic       e_lst;
        logic [1:0] e_src;
        logic [3:0] e_rdy;
        logic       e_busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(logic r, logic [3:0] vld, logic [3:0] lst, logic rdy,
                                 logic [7:0] tag, logic ev, logic el, logic [1:0] es,
                                 logic [3:0] er, logic eb);
        vec_t x;
        x.rst = r; x.vld = vld; x.lst = lst; x.rdy = rdy; x.tag = tag;
        x.e_vld = ev; x.e_lst = el; x.e_src = es; x.e_rdy = er; x.e_busy = eb;
        return x;
    endfunction

    // Beat data encodes the tag and the producing requester.
    function automatic logic [`P2P_DATA_W-1:0] mkd(logic [7:0] tag, int i);
        return `P2P_DATA_W'((64'(tag) << 8) | 64'(i));
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        rst4 = 1'b1; v4 = '0; l4 = '0; blen4 = '0; qnum4 = '0; data4 = '0; st4.ready = 1'b1;
        rst3 = 1'b1; v3 = '0; l3 = '0; blen3 = '0; qnum3 = '0; data3 = '0; st3.ready = 1'b1;

        // reset state
        vt.push_back(mkv(1, 4'b0000, 4'b0000, 1, 8'h00, 0, 0, 0, 4'b0000, 0));
        vt.push_back(mkv(0, 4'b0000, 4'b0000, 1, 8'h01, 0, 0, 0, 4'b0000, 0));
        // 0 and 2 each send 3 beats; then rr_ptr=3 shows as 3 winning over 0,1
        vt.push_back(mkv(0, 4'b0101, 4'b0000, 1, 8'h10, 1, 0, 0, 4'b0001, 0));
        vt.push_back(mkv(0, 4'b0101, 4'b0000, 1, 8'h11, 1, 0, 0, 4'b0001, 1));
        vt.push_back(mkv(0, 4'b0101, 4'b0001, 1, 8'h12, 1, 1, 0, 4'b0001, 1));
        vt.push_back(mkv(0, 4'b0100, 4'b0000, 1, 8'h13, 1, 0, 2, 4'b0100, 0));
        vt.push_back(mkv(0, 4'b0100, 4'b0000, 1, 8'h14, 1, 0, 2, 4'b0100, 1));
        vt.push_back(mkv(0, 4'b0100, 4'b0100, 1, 8'h15, 1, 1, 2, 4'b0100, 1));
        vt.push_back(mkv(0, 4'b1011, 4'b1011, 1, 8'h16, 1, 1, 3, 4'b1000, 0));
        vt.push_back(mkv(0, 4'b0011, 4'b0011, 1, 8'h17, 1, 1, 0, 4'b0001, 0));
        vt.push_back(mkv(0, 4'b0010, 4'b0010, 1, 8'h18, 1, 1, 1, 4'b0010, 0));
        vt.push_back(mkv(0, 4'b0000, 4'b0000, 1, 8'h19, 0, 0, 0, 4'b0000, 0));
        // owner 1 stalls for 4 cycles mid-message while 0 waits
        vt.push_back(mkv(0, 4'b0010, 4'b0000, 1, 8'h20, 1, 0, 1, 4'b0010, 0));
        vt.push_back(mkv(0, 4'b0011, 4'b0000, 1, 8'h21, 1, 0, 1, 4'b0010, 1));
        vt.push_back(mkv(0, 4'b0001, 4'b0000, 1, 8'h22, 0, 0, 1, 4'b0000, 1));
        vt.push_back(mkv(0, 4'b0001, 4'b0000, 1, 8'h23, 0, 0, 1, 4'b0000, 1));
        vt.push_back(mkv(0, 4'b0001, 4'b0000, 1, 8'h24, 0, 0, 1, 4'b0000, 1));
        vt.push_back(mkv(0, 4'b0001, 4'b0000, 1, 8'h25, 0, 0, 1, 4'b0000, 1));
        vt.push_back(mkv(0, 4'b0011, 4'b0000, 1, 8'h26, 1, 0, 1, 4'b0010, 1));
        vt.push_back(mkv(0, 4'b0011, 4'b0010, 1, 8'h27, 1, 1, 1, 4'b0010, 1));
        vt.push_back(mkv(0, 4'b0001, 4'b0001, 1, 8'h28, 1, 1, 0, 4'b0001, 0));
        // 3 presented under backpressure; later arrival of 0 must not displace it
        vt.push_back(mkv(0, 4'b1000, 4'b0000, 0, 8'h30, 1, 0, 3, 4'b0000, 0));
        vt.push_back(mkv(0, 4'b1001, 4'b0000, 0, 8'h30, 1, 0, 3, 4'b0000, 1));
        vt.push_back(mkv(0, 4'b1001, 4'b1000, 1, 8'h30, 1, 1, 3, 4'b1000, 1));
        vt.push_back(mkv(0, 4'b0001, 4'b0001, 1, 8'h31, 1, 1, 0, 4'b0001, 0));
        // reset in the middle of a message from 1
        vt.push_back(mkv(0, 4'b0010, 4'b0000, 1, 8'h40, 1, 0, 1, 4'b0010, 0));
        vt.push_back(mkv(0, 4'b0010, 4'b0000, 1, 8'h41, 1, 0, 1, 4'b0010, 1));
        vt.push_back(mkv(1, 4'b0010, 4'b0000, 1, 8'h42, 1, 0, 1, 4'b0010, 1));
        vt.push_back(mkv(0, 4'b0011, 4'b0001, 1, 8'h43, 1, 1, 0, 4'b0001, 0));
        vt.push_back(mkv(0, 4'b0000, 4'b0000, 1, 8'h44, 0, 0, 0, 4'b0000, 0));

        repeat (2) @(negedge clk);
        rst3 = 1'b0;

        for (int k = 0; k < vt.size(); k++) begin
            @(negedge clk);
            rst4 = vt[k].rst; v4 = vt[k].vld; l4 = vt[k].lst; st4.ready = vt[k].rdy;
            for (int i = 0; i < 4; i++) begin
                data4[i] = mkd(vt[k].tag, i);
                blen4[i] = `MSG_BLEN_WIDTH'(100 + i);
                qnum4[i] = 8'(16 + i);
            end
            #1;
            chk($sformatf("v%0d.valid", k), 64'(st4.valid), 64'(vt[k].e_vld));
            chk($sformatf("v%0d.in_ready", k), 64'(rdy4), 64'(vt[k].e_rdy));
            chk($sformatf("v%0d.busy", k), 64'(busy4), 64'(vt[k].e_busy));
            if (vt[k].e_vld || vt[k].e_busy)
                chk($sformatf("v%0d.owner", k), 64'(own4), 64'(vt[k].e_src));
            if (vt[k].e_vld) begin
                chk($sformatf("v%0d.last", k), 64'(st4.last), 64'(vt[k].e_lst));
                chk($sformatf("v%0d.data", k), 64'(st4.data), 64'(mkd(vt[k].tag, int'(vt[k].e_src))));
                chk($sformatf("v%0d.blen", k), 64'(st4.blen), 64'(100 + int'(vt[k].e_src)));
                chk($sformatf("v%0d.qnum", k), 64'(st4.qnum), 64'(16 + int'(vt[k].e_src)));
            end else begin
                chk($sformatf("v%0d.data_idle", k), 64'(st4.data), 64'd0);
            end
        end

        // REQ_NUM=3: all valid, single-beat -> 0,1,2,0,1,2
        begin
            logic [1:0] exp3;
            exp3 = 2'd0;
            @(negedge clk);
            v3 = 3'b111; l3 = 3'b111; st3.ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                data3[i] = mkd(8'h50, i);
                blen3[i] = `MSG_BLEN_WIDTH'(i);
                qnum3[i] = 8'(i);
            end
            for (int c = 0; c < 6; c++) begin
                #1;
                chk($sformatf("rr3.c%0d.owner", c), 64'(own3), 64'(exp3));
                chk($sformatf("rr3.c%0d.in_ready", c), 64'(rdy3), 64'(3'b001 << exp3));
                chk($sformatf("rr3.c%0d.data", c), 64'(st3.data), 64'(mkd(8'h50, int'(exp3))));
                exp3 = (exp3 == 2'd2) ? 2'd0 : exp3 + 2'd1;
                @(negedge clk);
            end
            v3 = '0; l3 = '0;
        end

`ifdef TGT_PYLD_ARB_STAT_EN
        @(negedge clk);
        rst4 = 1'b1; v4 = '0; l4 = '0; st4.ready = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        chk("stat.reset", 64'(cnt4), 64'd0);
        @(negedge clk);
        v4 = 4'b0100; l4 = 4'b0100;
        repeat (65537) @(negedge clk);
        v4 = '0; l4 = '0;
        @(negedge clk);
        chk("stat.cnt0", 64'(cnt4[0]), 64'd0);
        chk("stat.cnt1", 64'(cnt4[1]), 64'd0);
        chk("stat.cnt2", 64'(cnt4[2]), 64'd1);
        chk("stat.cnt3", 64'(cnt4[3]), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tgt_pyld_st_arb.md
# tgt_pyld_st_arb

Round-robin, message-atomic arbiter that shares the target P2P payload-buffer store port (`st_pyld_req_*`) among `REQ_NUM` payload producers. It sits directly upstream of the payload buffer's store port. A grant is held from a message's first beat until its `last` beat is accepted, so the buffer's block-offset sequencing never interleaves two messages. Output valid and output fields stay stable from first presentation until accepted.

## Interface
Parameters:
- `REQ_NUM`, default 4: number of requesters, range 2..16.
- `REQ_IDX_W`, default `$clog2(REQ_NUM)`: width of requester index.

Ports. Per-requester buses are flattened, with requester i in slice i.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in `REQ_NUM`: per-requester beat valid.
- `in_last` in `REQ_NUM`: per-requester last beat of message.
- `in_blen` in `REQ_NUM*`MSG_BLEN_WIDTH``: per-requester message byte length.
- `in_qnum` in `REQ_NUM*8`: per-requester queue number.
- `in_data` in `REQ_NUM*`P2P_DATA_W``: per-requester beat data.
- `in_ready` out `REQ_NUM`: per-requester ready, one-hot or zero.
- `st_pyld_req_valid` out 1, `st_pyld_req_last` out 1, `st_pyld_req_blen` out `MSG_BLEN_WIDTH`, `st_pyld_req_qnum` out 8, `st_pyld_req_data` out `P2P_DATA_W`: merged store stream.
- `st_pyld_req_ready` in 1: store port ready.
- `arb_owner` out `REQ_IDX_W`: currently selected requester.
- `arb_busy` out 1: equals `lock`.
- `msg_cnt` out `REQ_NUM*16`: exists only with `TGT_PYLD_ARB_STAT_EN`.

## Operation
- State: `lock` (1b), `owner` (`REQ_IDX_W`), `rr_ptr` (`REQ_IDX_W`). Two states:
  - IDLE: `lock`=0.
  - LOCKED: `lock`=1.
- Selection `sel`:
  - LOCKED: `sel` = `owner`.
  - IDLE: `sel` = first i with `in_valid[i]`=1, scanning `rr_ptr`, `rr_ptr`+1, … modulo `REQ_NUM`.
- Merged stream:
  - `st_pyld_req_valid` = LOCKED ? `in_valid[owner]` : |`in_valid`.
  - All other `st_pyld_req_*` fields mux from slice `sel`.
- `in_ready[i]` = (i==`sel`) & `st_pyld_req_ready` & `st_pyld_req_valid`. Requesters not selected see 0.
- Handshake `hs` = `st_pyld_req_valid` & `st_pyld_req_ready`.
- Transitions, evaluated every cycle:
  - `hs` & `st_pyld_req_last`: go to IDLE; `rr_ptr` <= (`sel`+1) mod `REQ_NUM`. Wrap uses an explicit compare, not power-of-two truncation.
  - `hs` & !last: go to LOCKED; `owner` <= `sel`.
  - IDLE & `st_pyld_req_valid` & !`st_pyld_req_ready`: go to LOCKED; `owner` <= `sel`. This freezes the choice so a newly arriving higher-priority valid cannot change the presented beat.
  - Otherwise hold.
- LOCKED and the owner deasserts valid mid-message:
  - Output valid is 0.
  - Lock is held; no other requester is served until the owner's last beat.
- Single-beat message (`last` on first beat), accepted in IDLE: stays IDLE, `rr_ptr` advances.
- `arb_owner` = `sel`.
- No checking of `blen`/`qnum` consistency within a message; these pass through unmodified.

## Timing
- Zero-cycle datapath: every output except the state registers is combinational from the inputs. Throughput is one beat per cycle, including back-to-back messages from different requesters.
- Lock and round-robin decisions take effect the cycle after the triggering handshake.
- Reset values:
  - `lock`=0, `owner`=0, `rr_ptr`=0, `msg_cnt`=0.
  - Consequently all `st_pyld_req_*` outputs, `in_ready` and `arb_busy` are 0 while `in_valid`=0.
- Reset asserted mid-message: state is cleared on the next edge. Any partial message is abandoned and the upstream requester is responsible for it. After reset, index 0 has top priority.
- `in_ready` depends combinationally on `st_pyld_req_ready`. Requesters must not make `in_valid` depend on `in_ready`.

## Configuration
- Macro `TGT_PYLD_ARB_STAT_EN`.
- Defined:
  - Port `msg_cnt` and per-requester 16-bit counters exist.
  - Counter i increments on each `hs` & `st_pyld_req_last` with `sel`==i.
  - Counters wrap 0xFFFF→0 and clear on `rst`.
- Undefined: the port and counters are absent; the arbitration behaviour is identical.

## Test plan
- Requesters 0 and 2 each assert valid with a 3-beat message in the same cycle, ready=1 constantly → beats from 0 on cycles 0-2, then 2 on cycles 3-5; no interleave; `rr_ptr`=3 afterwards.
- Owner 1 drops valid for 4 cycles after beat 1 of 4 while requester 0 is valid → output valid=0 for those 4 cycles, `in_ready[0]`=0 throughout, then 1 completes, then 0 is served.
- Requester 3 presents beat 0 with ready=0; requester 0 asserts valid on the next cycle → the output still carries requester 3's data until accepted.
- `REQ_NUM`=3, all valid with single-beat messages → grant order 0,1,2,0,1,2 (wrap without index 3).
- `rst` pulsed during beat 2 of a 4-beat message from requester 1 → the next cycle `arb_busy`=0 and requester 0 is selected when valid.
- With `TGT_PYLD_ARB_STAT_EN`, 65537 single-beat messages from requester 2 → `msg_cnt[2]`=1; other counters 0.
